// File: rtl/lsu_pkg.sv
// Shared types for the RV32I load/store unit: FSM states, funct3 codes,
// access-size encoding and the load-lane extraction helper.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    // Everything about an accepted access that must survive until the bus answers.
    typedef struct packed {
        logic       we;
        size_e      size;
        logic       uns;
        logic [1:0] off;
    } op_t;

    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input size_e       size,
                                                 input logic        uns);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            SZ_B:    return uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            SZ_H:    return uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-wide request/acknowledge data bus between the load/store unit (master)
// and memory (slave).
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_be;
    logic [31:0]       bus_wdata;
    logic              bus_ack;
    logic [31:0]       bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational funct3 decode for the load/store unit: size/sign, byte enables,
// store-lane replication and illegal/misaligned detection.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic        is_load_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output size_e       size_o,
    output logic        uns_o,
    output logic        illegal_o,
    output logic        misaligned_o
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the cases can infer a latch.
        be_o         = 4'b1111;
        wdata_o      = wdata_i;
        size_o       = SZ_W;
        uns_o        = 1'b0;
        illegal_o    = 1'b0;
        misaligned_o = 1'b0;

        case (funct3_i)
            F3_B:  size_o = SZ_B;
            F3_H:  size_o = SZ_H;
            F3_W:  size_o = SZ_W;
            F3_BU: begin size_o = SZ_B; uns_o = 1'b1; illegal_o = !is_load_i; end
            F3_HU: begin size_o = SZ_H; uns_o = 1'b1; illegal_o = !is_load_i; end
            default: illegal_o = 1'b1;
        endcase

        case (size_o)
            SZ_B: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            SZ_H: begin
                be_o         = off_i[1] ? 4'b1100 : 4'b0011;
                wdata_o      = {2{wdata_i[15:0]}};
                misaligned_o = off_i[0];
            end
            default: begin
                be_o         = 4'b1111;
                misaligned_o = (off_i != 2'b00);
            end
        endcase

        // Loads always fetch the full word; the lane is picked when the data returns.
        if (is_load_i) be_o = 4'b1111;
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store engine: IDLE -> BUSY -> DONE handshake with a word bus,
// pipeline stall while outstanding. Optional bus timeout: `define LSU_BUS_TIMEOUT_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic               kill,
    input  logic [2:0]         funct3,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               stall,
    output logic               err,
    load_store_unit_if.master  bus
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [3:0]          be_q;
    logic [31:0]         wdata_q;
    op_t                 op_q;
    logic                killed_q;
    logic [31:0]         rdata_q, rdata_d;

    logic                go, capture, discard, timeout;
    logic [3:0]          be;
    logic [31:0]         st_data;
    size_e               size;
    logic                uns, illegal, misaligned;

    // A simultaneous read and write is treated as a load.
    assign go = (mem_read | mem_write) & ~kill;

    lsu_align u_align (
        .funct3_i     (funct3),
        .is_load_i    (mem_read),
        .off_i        (addr[1:0]),
        .wdata_i      (wdata),
        .be_o         (be),
        .wdata_o      (st_data),
        .size_o       (size),
        .uns_o        (uns),
        .illegal_o    (illegal),
        .misaligned_o (misaligned)
    );

`ifdef LSU_BUS_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset)                cnt_q <= '0;
        else if (capture)         cnt_q <= '0;
        else if (state_q == BUSY) cnt_q <= cnt_q + CNT_W'(1);
    end

    assign timeout = (state_q == BUSY) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout            = 1'b0;
`endif

    // A flush during BUSY still completes the bus cycle but must not write rdata.
    assign discard = killed_q | kill;

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        stall   = 1'b0;
        err     = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (go) begin
                    if (illegal || misaligned) begin
                        err = 1'b1;
                    end else begin
                        capture = 1'b1;
                        stall   = 1'b1;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (bus.bus_ack) begin
                    state_d = DONE;
                    if (!op_q.we && !discard)
                        rdata_d = extract_load(bus.bus_rdata, op_q.off, op_q.size, op_q.uns);
                end else if (timeout) begin
                    err     = 1'b1;
                    state_d = DONE;
                    if (!op_q.we && !discard) rdata_d = '0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            op_q     <= '0;
            killed_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            rdata_q <= rdata_d;
            if (capture) begin
                addr_q   <= {addr[ADDR_W-1:2], 2'b00};
                be_q     <= be;
                wdata_q  <= st_data;
                op_q     <= '{we: !mem_read, size: size, uns: uns, off: addr[1:0]};
                killed_q <= 1'b0;
            end else if (state_q == BUSY && kill) begin
                killed_q <= 1'b1;
            end
        end
    end

    assign rdata         = rdata_q;
    assign bus.bus_req   = (state_q == BUSY);
    assign bus.bus_we    = op_q.we;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: transaction-level model of expected
// per-cycle outputs, checked every cycle, plus hand-computed literal pins.
module tb_load_store_unit;

    localparam int TO_CYC = 4;
`ifdef LSU_BUS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk, reset, mem_read, mem_write, kill;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, rdata;
    logic        stall, err;

    load_store_unit_if #(.ADDR_W(32)) bif ();

    load_store_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .kill      (kill),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .err       (err),
        .bus       (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    endtask

    // Expected per-cycle outputs, written by the driver and compared mid-cycle.
    logic        chk_en = 1'b0, chk_bus = 1'b0, chk_wd = 1'b0;
    logic        exp_stall, exp_err, exp_req, exp_we;
    logic [31:0] exp_addr, exp_wdata, m_rdata;
    logic [3:0]  exp_be;

    int          stall_cnt;
    logic        seen_req, seen_we;
    logic [31:0] seen_addr, seen_wdata;
    logic [3:0]  seen_be;

    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", {31'b0, stall}, {31'b0, exp_stall});
            check("err", {31'b0, err}, {31'b0, exp_err});
            check("bus_req", {31'b0, bif.bus_req}, {31'b0, exp_req});
            check("rdata", rdata, m_rdata);
            if (chk_bus) begin
                check("bus_we", {31'b0, bif.bus_we}, {31'b0, exp_we});
                check("bus_addr", bif.bus_addr, exp_addr);
                check("bus_be", {28'b0, bif.bus_be}, {28'b0, exp_be});
                if (chk_wd) check("bus_wdata", bif.bus_wdata, exp_wdata);
            end
            if (stall === 1'b1) stall_cnt++;
            if (bif.bus_req === 1'b1) begin
                seen_req   = 1'b1;
                seen_we    = bif.bus_we;
                seen_addr  = bif.bus_addr;
                seen_be    = bif.bus_be;
                seen_wdata = bif.bus_wdata;
            end
        end
    end

    // ---- behavioural model: access rules written as plain arithmetic ----
    function automatic bit mdl_legal(input bit ld, input logic [2:0] f3);
        if (ld) return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        return f3 inside {3'b000, 3'b001, 3'b010};
    endfunction

    function automatic int mdl_bytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit mdl_aligned(input logic [2:0] f3, input logic [31:0] a);
        return (int'(a[1:0]) % mdl_bytes(f3)) == 0;
    endfunction

    function automatic logic [3:0] mdl_be(input bit ld, input logic [2:0] f3, input logic [31:0] a);
        int mask;
        if (ld) return 4'hF;
        mask = ((1 << mdl_bytes(f3)) - 1) << int'(a[1:0]);
        return mask[3:0];
    endfunction

    function automatic logic [31:0] mdl_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (mdl_bytes(f3))
            1:       return {24'b0, wd[7:0]} * 32'h0101_0101;
            2:       return {16'b0, wd[15:0]} * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] mdl_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] word);
        int          nb;
        logic [31:0] v, mask;
        nb = mdl_bytes(f3);
        if (nb == 4) return word;
        v    = word >> (8 * int'(a[1:0]));
        mask = (32'd1 << (8 * nb)) - 32'd1;
        v    = v & mask;
        if (!f3[2] && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic set_idle_exp();
        exp_stall = 1'b0;
        exp_err   = 1'b0;
        exp_req   = 1'b0;
        chk_bus   = 1'b0;
    endtask

    // One Memory-stage access. waits = BUSY cycles before ack; kill_at/reset_at
    // index a BUSY cycle (-1 = never).
    task automatic run_access(input logic rd, input logic wr, input logic kl,
                              input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input int waits,
                              input logic [31:0] word, input int kill_at,
                              input int reset_at);
        bit ld, go, ok, killed, rst_hit, timed_out;
        ld = rd;
        go = (rd || wr) && !kl;
        ok = go && mdl_legal(ld, f3) && mdl_aligned(f3, a);
        killed = 1'b0; rst_hit = 1'b0; timed_out = 1'b0;

        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; kill = kl; funct3 = f3; addr = a; wdata = wd;
        bif.bus_ack = 1'b0; bif.bus_rdata = 32'hCAFE_F00D;
        set_idle_exp();
        exp_err   = go && !ok;
        exp_stall = ok;

        if (ok) begin
            exp_we    = !ld;
            exp_addr  = {a[31:2], 2'b00};
            exp_be    = mdl_be(ld, f3, a);
            exp_wdata = mdl_wdata(f3, wd);
            chk_wd    = !ld;
            for (int k = 0; k < 64; k++) begin
                @(posedge clk); #1;
                kill  = (k == kill_at);
                reset = (k == reset_at);
                bif.bus_ack   = (k == waits);
                bif.bus_rdata = (k == waits) ? word : 32'hCAFE_F00D;
                exp_req = 1'b1; exp_stall = 1'b1; exp_err = 1'b0; chk_bus = 1'b1;
                if (kill) killed = 1'b1;
                if (reset) begin
                    rst_hit = 1'b1;
                    break;
                end else if (k == waits) begin
                    break;
                end else if (TO_EN && k == TO_CYC - 1) begin
                    exp_err   = 1'b1;
                    timed_out = 1'b1;
                    break;
                end
            end

            @(posedge clk); #1;
            if (rst_hit) begin
                // Reset landed mid-transaction: back to reset values, late ack ignored.
                reset = 1'b0; mem_read = 1'b0; mem_write = 1'b0; kill = 1'b0;
                bif.bus_ack = 1'b1; bif.bus_rdata = 32'h1234_5678;
                set_idle_exp();
                m_rdata = 32'h0;
                chk_bus = 1'b1; chk_wd = 1'b1;
                exp_we = 1'b0; exp_addr = 32'h0; exp_be = 4'h0; exp_wdata = 32'h0;
            end else begin
                // DONE cycle: inputs still held, yet no new request may be taken.
                kill = 1'b0; bif.bus_ack = 1'b0; bif.bus_rdata = 32'hCAFE_F00D;
                set_idle_exp();
                if (ld && !killed) m_rdata = timed_out ? 32'h0 : mdl_load(f3, a, word);
            end
        end

        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0; kill = 1'b0; reset = 1'b0;
        bif.bus_ack = 1'b0;
        set_idle_exp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; kill = 1'b0;
        funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
        bif.bus_ack = 1'b0; bif.bus_rdata = 32'h0;
        m_rdata = 32'h0; stall_cnt = 0; seen_req = 1'b0;
        set_idle_exp();

        @(posedge clk); #1;
        exp_we = 1'b0; exp_addr = 32'h0; exp_be = 4'h0; exp_wdata = 32'h0;
        chk_bus = 1'b1; chk_wd = 1'b1; chk_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk_bus = 1'b0;

        // Zero-wait LW
        stall_cnt = 0;
        run_access(1, 0, 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEAD_BEEF, -1, -1);
        check("lw_stall_cycles", stall_cnt, 32'd2);
        check("lw_rdata", rdata, 32'hDEAD_BEEF);
        check("lw_bus_addr", seen_addr, 32'h100);
        check("lw_bus_be", {28'b0, seen_be}, 32'hF);

        // LB / LBU on the top lane
        run_access(1, 0, 0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF_0000, -1, -1);
        check("lb_rdata", rdata, 32'hFFFF_FF80);
        run_access(1, 0, 0, 3'b100, 32'h103, 32'h0, 0, 32'h80FF_0000, -1, -1);
        check("lbu_rdata", rdata, 32'h0000_0080);

        // SH to the upper half
        run_access(0, 1, 0, 3'b001, 32'h202, 32'h1234_ABCD, 2, 32'h0, -1, -1);
        check("sh_bus_we", {31'b0, seen_we}, 32'h1);
        check("sh_bus_addr", seen_addr, 32'h200);
        check("sh_bus_be", {28'b0, seen_be}, 32'hC);
        check("sh_bus_wdata", seen_wdata, 32'hABCD_ABCD);
        check("sh_rdata_kept", rdata, 32'h0000_0080);

        // Misaligned LW: error pulse, no bus request
        seen_req = 1'b0;
        run_access(1, 0, 0, 3'b010, 32'h101, 32'h0, 0, 32'h0, -1, -1);
        check("mis_lw_no_req", {31'b0, seen_req}, 32'h0);
        check("mis_lw_rdata_kept", rdata, 32'h0000_0080);

        // Halfword loads, byte and word stores
        run_access(1, 0, 0, 3'b001, 32'h102, 32'h0, 0, 32'h8001_1234, -1, -1);
        check("lh_rdata", rdata, 32'hFFFF_8001);
        run_access(1, 0, 0, 3'b101, 32'h100, 32'h0, 3, 32'h0000_F00D, -1, -1);
        check("lhu_rdata", rdata, 32'h0000_F00D);
        run_access(0, 1, 0, 3'b000, 32'h101, 32'h0000_00A5, 1, 32'h0, -1, -1);
        check("sb_bus_be", {28'b0, seen_be}, 32'h2);
        check("sb_bus_wdata", seen_wdata, 32'hA5A5_A5A5);
        run_access(0, 1, 0, 3'b010, 32'h10C, 32'h0123_4567, 1, 32'h0, -1, -1);

        // Illegal codes, misaligned SH, killed request
        run_access(1, 0, 0, 3'b011, 32'h10, 32'h0, 0, 32'h0, -1, -1);
        run_access(0, 1, 0, 3'b100, 32'h10, 32'h0, 0, 32'h0, -1, -1);
        run_access(0, 1, 0, 3'b001, 32'h203, 32'h0, 0, 32'h0, -1, -1);
        run_access(1, 0, 1, 3'b010, 32'h10, 32'h0, 0, 32'h0, -1, -1);

        // Read and write together: the load wins (LBU is illegal as a store)
        run_access(1, 1, 0, 3'b100, 32'h101, 32'h0, 0, 32'h0000_7F00, -1, -1);
        check("rdwr_lbu_rdata", rdata, 32'h0000_007F);

        // Kill during BUSY: transaction completes, result discarded
        run_access(1, 0, 0, 3'b010, 32'h104, 32'h0, 2, 32'h5555_5555, 1, -1);
        check("kill_busy_rdata", rdata, 32'h0000_007F);

        // Reset in the second of three wait cycles
        run_access(1, 0, 0, 3'b010, 32'h108, 32'h0, 3, 32'h9999_9999, -1, 1);
        check("reset_mid_rdata", rdata, 32'h0);

        run_access(1, 0, 0, 3'b010, 32'h10, 32'h0, 0, 32'h1357_2468, -1, -1);
        check("post_reset_lw", rdata, 32'h1357_2468);

        // Long wait: times out with the feature, completes normally without it
        run_access(1, 0, 0, 3'b010, 32'h100, 32'h0, 10, 32'h0BAD_CAFE, -1, -1);
        check("long_wait_rdata", rdata, TO_EN ? 32'h0 : 32'h0BAD_CAFE);

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage load/store engine between the RV32I pipeline datapath and a word-wide data bus with a request/acknowledge handshake.
- Consumes the Memory-stage effective address and store data, plus load/store controls and funct3 from the controller.
- Drives byte-lane requests onto the bus and returns aligned, sign- or zero-extended load data as the datapath's memory read data.
- Asserts a stall toward the hazard logic while a bus transaction is outstanding.

Parameters:
- ADDR_W, 32, byte address width.
- TIMEOUT_CYCLES, 255, bus wait limit; used only when the optional feature is compiled in.

Ports:
- clk  input  1  single clock, all state on rising edge.
- reset  input  1  synchronous, active-high.
- mem_read  input  1  Memory-stage instruction is a load.
- mem_write  input  1  Memory-stage instruction is a store.
- kill  input  1  Memory-stage instruction is flushed.
- funct3  input  3  access size and signedness.
- addr  input  ADDR_W  effective byte address (ALU result).
- wdata  input  32  store data (rs2 value).
- rdata  output  32  formatted load data to the Write Back register.
- stall  output  1  hold the pipeline.
- err  output  1  one-cycle pulse: misaligned access, illegal funct3, or timeout.
- bus_req  output  1  bus request valid.
- bus_we  output  1  1 = write.
- bus_addr  output  ADDR_W  word address; bits [1:0] are forced to 0.
- bus_be  output  4  byte enables.
- bus_wdata  output  32  lane-steered store data.
- bus_ack  input  1  transaction complete; bus_rdata is valid in the same cycle.
- bus_rdata  input  32  raw read word.

Behaviour:
- Reset: state IDLE; rdata=0, stall=0, err=0, bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0.
- A reset asserted mid-transaction forces IDLE and drops bus_req at that edge. The late bus_ack is ignored.
- funct3 decode:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal.
- Access is defined as go = (mem_read | mem_write) & ~kill. If mem_read and mem_write are both high, mem_read wins.
- Byte enables:
  - SB: be = 0001 << addr[1:0], store byte replicated on all four lanes.
  - SH: be = 0011 << (2*addr[1]), store halfword replicated on both halves.
  - SW: be = 1111.
  - Loads: be = 1111.
- A halfword access with addr[0]=1, or a word access with addr[1:0]≠0, is misaligned.
- IDLE state:
  - go with a legal, aligned access: capture address, be, steered data and op; move to BUSY. stall=1 combinationally in this same cycle.
  - go with an illegal or misaligned access: no bus activity, err=1 for this cycle, stall=0, rdata unchanged.
  - No go: stay in IDLE, stall=0.
- BUSY state:
  - bus_req=1 and all bus outputs are held stable; stall=1.
  - On bus_ack: for loads, register the extracted lane (LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through) into rdata; move to DONE.
  - A kill arriving while in BUSY does not abandon the transaction. It is completed, and a load result is discarded (rdata not updated).
- DONE state:
  - stall=0 for exactly one cycle so the pipeline advances; rdata is valid; bus_req=0.
  - Next state is always IDLE. A new request is never accepted in DONE.
- Minimum latency: a zero-wait bus (ack in the first BUSY cycle) gives 2 stall cycles, then 1 DONE cycle.
- rdata holds its value until the next load completes. Stores do not modify rdata.

Optional Feature:
- Macro LSU_BUS_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit-or-wider counter runs in BUSY and is cleared on entry to BUSY.
  - When it reaches TIMEOUT_CYCLES without bus_ack: err=1 for one cycle, bus_req drops, the state moves to DONE, and rdata is set to 0 for a load.
  - bus_ack takes priority if it coincides with the timeout.
- Without the macro: no counter; BUSY waits indefinitely for bus_ack.

Decomposition:
- Package lsu_pkg holds:
  - State encoding: IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - Size/sign enum.
- One natural sub-module: lsu_align, purely combinational. It provides store lane steering and be generation, misalign/illegal detection, and load extraction with extension. Instantiate it once for the store path and reuse its extract function for the load path.

Test Plan:
- Zero-wait LW: addr=0x100, bus_rdata=0xDEADBEEF, ack in first BUSY cycle → bus_addr=0x100, be=1111, stall high for 2 cycles, rdata=0xDEADBEEF in DONE.
- LB and LBU: addr=0x103, bus_rdata=0x80FF_0000 → LB gives rdata=0xFFFFFF80; LBU gives rdata=0x00000080.
- SH: addr=0x202, wdata=0x1234ABCD → bus_we=1, bus_addr=0x200, be=1100, bus_wdata=0xABCDABCD; rdata unchanged.
- Misaligned LW at addr=0x101 → err pulses for 1 cycle, bus_req never asserts, stall=0.
- Three wait states with reset asserted in the second BUSY cycle → bus_req=0 and state IDLE after that edge; a late ack causes no rdata change.
- With LSU_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack → err after 4 BUSY cycles, rdata=0, stall released in the following DONE cycle.
